imem_fetch_responder: RTL and testbench

//  Instruction-memory responder: the far end of the PC/fetch interface. Accepts

---
 rtl/imem_fetch_if.sv | 21 ++
 rtl/imem_fetch_responder.sv | 125 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Fetch request/response bus between the PC/fetch stage (master) and the
// instruction-memory responder (slave).
interface imem_fetch_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts byte-address fetches, returns 32-bit
// words after LATENCY cycles through a credit-limited response FIFO, with a
// side load port for filling the array.
// Optional feature: define IMEM_ALIGN_CHECK_EN to fault misaligned fetches.
module imem_fetch_responder #(
  parameter int unsigned AW         = 10,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imem_fetch_if.slave   bus,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 33;  // {err, data}

  logic [31:0]   mem [2**AW];
  logic [CW-1:0] outstanding_q;
  logic          accept;
  logic          pop;
  logic [AW-1:0] in_idx;
  logic          in_err;
  logic [EW-1:0] in_ent;
  logic          push_v;
  logic [EW-1:0] push_ent;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] fcnt_q;
  logic [EW-1:0] last_q;

  assign bus.req_ready_o = !rst_i && (outstanding_q < CW'(FIFO_DEPTH));
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign pop             = bus.rsp_valid_o && bus.rsp_ready_i;
  assign in_idx          = bus.req_addr_i[AW+1:2];

  // Load port write; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ld_we_i) mem[ld_addr_i] <= ld_data_i;
  end

`ifdef IMEM_ALIGN_CHECK_EN
  assign in_err = (|bus.req_addr_i[31:AW+2]) || (|bus.req_addr_i[1:0]);
`else
  // Byte offset is a don't-care when alignment is not checked.
  logic unused_align;
  assign unused_align = ^bus.req_addr_i[1:0];
  assign in_err = |bus.req_addr_i[31:AW+2];
`endif

  // Array read happens in the accept cycle, so a same-cycle load returns old data.
  always_comb begin
    in_ent = {in_err, 32'h0};
    if (!in_err) in_ent = {1'b0, mem[in_idx]};
  end

  generate
    if (LATENCY == 1) begin : g_nopipe
      assign push_v   = accept;
      assign push_ent = in_ent;
    end else begin : g_pipe
      logic [LATENCY-2:0] st_v;
      logic [EW-1:0]      st_e [LATENCY-1];

      // Delay line carrying accepted fetches toward the response FIFO.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          st_v <= '0;
          for (int unsigned i = 0; i < LATENCY - 1; i++) st_e[i] <= '0;
        end else begin
          st_v[0] <= accept;
          st_e[0] <= in_ent;
          for (int unsigned i = 1; i < LATENCY - 1; i++) begin
            st_v[i] <= st_v[i-1];
            st_e[i] <= st_e[i-1];
          end
        end
      end

      assign push_v   = st_v[LATENCY-2];
      assign push_ent = st_e[LATENCY-2];
    end
  endgenerate

  // FIFO storage; never overflows because credits bound everything in flight.
  always_ff @(posedge clk_i) begin
    if (push_v) fifo_mem[wr_ptr_q] <= push_ent;
  end

  // FIFO pointers, occupancy, last popped entry and credit counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fcnt_q        <= '0;
      last_q        <= '0;
      outstanding_q <= '0;
    end else begin
      if (push_v) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        last_q   <= fifo_mem[rd_ptr_q];
      end
      case ({push_v, pop})
        2'b10:   fcnt_q <= fcnt_q + CW'(1);
        2'b01:   fcnt_q <= fcnt_q - CW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      case ({accept, pop})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign bus.rsp_valid_o = (fcnt_q != '0);
  assign {bus.rsp_err_o, bus.rsp_data_o} = bus.rsp_valid_o ? fifo_mem[rd_ptr_q] : last_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Randomized bench for imem_fetch_responder against a transaction-level model:
// each accepted fetch becomes a queue entry with its earliest response cycle.
module tb_imem_fetch_responder;
  localparam int unsigned LAT = 2;
  localparam int unsigned FD  = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  imem_fetch_if bus ();

  imem_fetch_responder dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .ld_we_i   (ld_we),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          t;
  } ent_t;

  ent_t        q[$];
  ent_t        last;
  logic [31:0] mdl_mem [1024];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] a);
    ent_t r;
    r.e = (a[31:12] != 20'h0);
`ifdef IMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) r.e = 1'b1;
`endif
    r.d = r.e ? 32'h0 : mdl_mem[a[11:2]];
    r.t = cyc + int'(LAT);
    return r;
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input logic rv, input logic [31:0] a, input logic rr,
                      input logic we, input logic [9:0] la, input logic [31:0] ld);
    logic   exp_v;
    logic   exp_rdy;
    ent_t   head;
    exp_v   = (q.size() > 0) && (q[0].t <= cyc);
    exp_rdy = (q.size() < int'(FD));
    head    = exp_v ? q[0] : last;
    check("rsp_valid", 32'(bus.rsp_valid_o), 32'(exp_v));
    check("req_ready", 32'(bus.req_ready_o), 32'(exp_rdy));
    check("rsp_data",  bus.rsp_data_o, head.d);
    check("rsp_err",   32'(bus.rsp_err_o), 32'(head.e));
    bus.req_valid_i = rv;
    bus.req_addr_i  = a;
    bus.rsp_ready_i = rr;
    ld_we   = we;
    ld_addr = la;
    ld_data = ld;
    if (exp_v && rr) last = q.pop_front();
    if (rv && exp_rdy) q.push_back(mk(a));
    if (we) mdl_mem[la] = ld;
    @(negedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 10'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    bus.req_valid_i = 1'b0;
    #1;
    check("rst_valid", 32'(bus.rsp_valid_o), 32'h0);
    check("rst_ready", 32'(bus.req_ready_o), 32'h0);
    check("rst_data",  bus.rsp_data_o, 32'h0);
    q.delete();
    last = '{32'h0, 1'b0, 0};
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] a;
    rst_i = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 32'h0;
    bus.rsp_ready_i = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    last = '{32'h0, 1'b0, 0};

    // Fill the whole array through the load port while in reset.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk_i);
      ld_we   = 1'b1;
      ld_addr = 10'(i);
      ld_data = (i < 4) ? 32'(32'h11 * (i + 1)) : $urandom;
      mdl_mem[i] = ld_data;
    end
    @(negedge clk_i);
    ld_we = 1'b0;
    #1;
    check("init_valid", 32'(bus.rsp_valid_o), 32'h0);
    check("init_ready", 32'(bus.req_ready_o), 32'h0);
    check("init_data",  bus.rsp_data_o, 32'h0);
    check("init_err",   32'(bus.rsp_err_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;

    // Back-to-back fetches of words 0..3.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0, 10'h0, 32'h0);
    idle(4);

    // Back-pressure: credits run out after FD accepts, then drain.
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 10'h0, 32'h0);
    idle(8);

    // Out-of-range and misaligned fetches.
    step(1'b1, 32'h0000_1000, 1'b1, 1'b0, 10'h0, 32'h0);
    idle(3);
    step(1'b1, 32'h0000_0002, 1'b1, 1'b0, 10'h0, 32'h0);
    idle(3);

    // Reset with two fetches in flight; array must survive.
    step(1'b1, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 1'b0, 10'h0, 32'h0);
    do_reset();
    idle(4);
    step(1'b1, 32'h0, 1'b1, 1'b0, 10'h0, 32'h0);
    idle(3);

    // Same-cycle load and fetch of word 1 returns old data, then new.
    step(1'b1, 32'h4, 1'b1, 1'b1, 10'h1, 32'hAA);
    step(1'b1, 32'h4, 1'b1, 1'b0, 10'h0, 32'h0);
    idle(3);

    // Randomized traffic with back-pressure and concurrent loads.
    for (int i = 0; i < 800; i++) begin
      case ($urandom % 10)
        0, 1, 2, 3, 4, 5, 6: a = {20'h0, 10'($urandom), 2'b00};
        7:       a = $urandom | 32'h0000_1000;
        8:       a = {20'h0, 10'($urandom), 2'($urandom)};
        default: a = $urandom;
      endcase
      if (i == 400) do_reset();
      step(($urandom % 4) != 0, a, (i % 100 < 50) ? (($urandom % 4) != 0) : (($urandom % 3) == 0),
           ($urandom % 8) == 0, 10'($urandom), $urandom);
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
